// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared owner and state types for the memory port arbiter
package mem_arb_pkg;
  typedef enum logic {OWN_CORE, OWN_DBG} owner_t;
  typedef enum logic {ARB, LOCKED} arb_state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin pick; req[0] is the core, req[1] the debug master
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last_owner,
  input  logic       mask_core,
  output logic [1:0] gnt
);
  logic core_ok;
  always_comb begin
    core_ok = req[0] & ~mask_core;
    gnt[0]  = core_ok & (~req[1] | (last_owner == OWN_DBG));
    gnt[1]  = req[1] & (~core_ok | (last_owner == OWN_CORE));
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory word port between the core and a debug master,
// with debug lock-out of the core and one-cycle read-response routing
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_stall,
  output logic              core_rvalid,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  input  logic              dbg_lock,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  arb_state_t state;
  owner_t     last_owner;
  owner_t     resp_owner;
  logic       resp_valid;
  logic [1:0] gnt;
  // the core stays masked only while the lock is still held; the exit cycle arbitrates normally
  rr_arbiter2 u_rr (
    .req        ({dbg_req, core_req}),
    .last_owner (last_owner),
    .mask_core  ((state == LOCKED) & dbg_lock),
    .gnt        (gnt)
  );
  always_comb begin
    core_gnt    = gnt[0] & ~rst;
    dbg_gnt     = gnt[1] & ~rst;
    core_stall  = core_req & ~gnt[0] & ~rst;
    mem_wen     = (core_gnt & core_we) | (dbg_gnt & dbg_we);
    mem_ren     = (core_gnt & ~core_we) | (dbg_gnt & ~dbg_we);
    mem_addr    = rst ? '0 : dbg_gnt ? dbg_addr : core_addr;
    mem_wdata   = rst ? '0 : dbg_gnt ? dbg_wdata : core_wdata;
    core_rvalid = resp_valid & (resp_owner == OWN_CORE) & ~rst;
    dbg_rvalid  = resp_valid & (resp_owner == OWN_DBG) & ~rst;
    rdata       = rst ? '0 : mem_rdata;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= ARB;
      last_owner <= OWN_DBG;
      resp_valid <= 1'b0;
      resp_owner <= OWN_CORE;
    end else begin
      state      <= (dbg_lock && (state == LOCKED || dbg_gnt)) ? LOCKED : ARB;
      if (core_gnt || dbg_gnt) last_owner <= dbg_gnt ? OWN_DBG : OWN_CORE;
      resp_valid <= mem_ren;
      resp_owner <= dbg_gnt ? OWN_DBG : OWN_CORE;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus constrained-random traffic checked
// every cycle against a transaction-level model of the arbitration rules
module tb_mem_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;
  logic clk = 0, rst = 1;
  logic core_req = 0, core_we = 0, dbg_req = 0, dbg_we = 0, dbg_lock = 0;
  logic [AW-1:0] core_addr = 0, dbg_addr = 0;
  logic [DW-1:0] core_wdata = 0, dbg_wdata = 0, mem_rdata = 0;
  logic core_gnt, core_stall, core_rvalid, dbg_gnt, dbg_rvalid, mem_wen, mem_ren;
  logic [DW-1:0] rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  int vectors = 0, miscompares = 0;
  bit m_locked = 0, m_last_dbg = 1, m_pend = 0, m_pend_dbg = 0;
  bit e_cw = 0, e_dw = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_stall(core_stall), .core_rvalid(core_rvalid),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_lock(dbg_lock),
    .rdata(rdata), .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // who may use the port this cycle, from the rules: lock excludes the core,
  // a lone requester wins, a tie goes to whoever was not served last
  task automatic compare();
    bit core_ok, cw, dw;
    @(negedge clk);
    core_ok = core_req && !(m_locked && dbg_lock);
    if (rst) begin cw = 0; dw = 0; end
    else if (core_ok && dbg_req) begin cw = m_last_dbg; dw = !m_last_dbg; end
    else begin cw = core_ok; dw = dbg_req; end
    e_cw = cw; e_dw = dw;
    check("core_gnt", {31'b0, core_gnt}, {31'b0, cw});
    check("dbg_gnt", {31'b0, dbg_gnt}, {31'b0, dw});
    check("core_stall", {31'b0, core_stall}, {31'b0, !rst && core_req && !cw});
    check("mem_wen", {31'b0, mem_wen}, {31'b0, (cw && core_we) || (dw && dbg_we)});
    check("mem_ren", {31'b0, mem_ren}, {31'b0, (cw && !core_we) || (dw && !dbg_we)});
    if (cw || dw) begin
      check("mem_addr", {16'b0, mem_addr}, {16'b0, dw ? dbg_addr : core_addr});
      check("mem_wdata", mem_wdata, dw ? dbg_wdata : core_wdata);
    end
    check("core_rvalid", {31'b0, core_rvalid}, {31'b0, !rst && m_pend && !m_pend_dbg});
    check("dbg_rvalid", {31'b0, dbg_rvalid}, {31'b0, !rst && m_pend && m_pend_dbg});
    if (!rst && m_pend) check("rdata", rdata, mem_rdata);
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      m_locked = 0; m_last_dbg = 1; m_pend = 0;
    end else begin
      m_pend = (e_cw && !core_we) || (e_dw && !dbg_we);
      m_pend_dbg = e_dw;
      if (e_cw || e_dw) m_last_dbg = e_dw;
      m_locked = dbg_lock && (m_locked || e_dw);
    end
    #1;
  endtask

  task automatic idle();
    core_req = 0; dbg_req = 0; dbg_lock = 0;
  endtask

  initial begin
    bit hold_c, hold_d;
    #1;
    core_req = 1; core_we = 0; core_addr = 16'h0040;
    for (int i = 0; i < 2; i++) begin
      compare();
      check("rst_core_gnt", {31'b0, core_gnt}, 32'd0);
      check("rst_mem_ren", {31'b0, mem_ren}, 32'd0);
      advance();
    end
    rst = 0;
    compare();
    check("post_rst_gnt", {31'b0, core_gnt}, 32'd1);
    check("post_rst_ren", {31'b0, mem_ren}, 32'd1);
    check("post_rst_addr", {16'b0, mem_addr}, 32'h0040);
    advance();
    core_addr = 16'h0010;
    compare(); advance();
    idle(); mem_rdata = 32'hDEADBEEF;
    compare();
    check("read_core_rvalid", {31'b0, core_rvalid}, 32'd1);
    check("read_rdata", rdata, 32'hDEADBEEF);
    check("read_dbg_rvalid", {31'b0, dbg_rvalid}, 32'd0);
    advance();
    dbg_req = 1; dbg_we = 1; dbg_addr = 16'h0200; dbg_wdata = 32'h5;
    compare(); advance();
    core_req = 1; core_we = 0; core_addr = 16'h0020; dbg_we = 0; dbg_addr = 16'h0030;
    for (int i = 0; i < 6; i++) begin
      compare();
      check("alt_core_gnt", {31'b0, core_gnt}, {31'b0, i % 2 == 0});
      check("alt_core_stall", {31'b0, core_stall}, {31'b0, i % 2 == 1});
      advance();
    end
    dbg_req = 0;
    compare(); advance();
    dbg_req = 1; dbg_we = 1; dbg_lock = 1;
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 16'h0100 + 16'(i); dbg_wdata = 32'hA0 + i;
      compare();
      check("lock_core_gnt", {31'b0, core_gnt}, 32'd0);
      advance();
    end
    dbg_lock = 0;
    compare();
    check("unlock_core_gnt", {31'b0, core_gnt}, 32'd1);
    advance();
    idle(); core_req = 1; core_we = 0; core_addr = 16'h0004;
    compare(); check("b2b_addr_core", {16'b0, mem_addr}, 32'h0004); advance();
    idle(); dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0008; mem_rdata = 32'h11111111;
    compare(); check("b2b_addr_dbg", {16'b0, mem_addr}, 32'h0008);
    check("b2b_core_rvalid", {31'b0, core_rvalid}, 32'd1);
    check("b2b_rdata_core", rdata, 32'h11111111);
    advance();
    idle(); mem_rdata = 32'h22222222;
    compare();
    check("b2b_dbg_rvalid", {31'b0, dbg_rvalid}, 32'd1);
    check("b2b_no_cross", {31'b0, core_rvalid}, 32'd0);
    check("b2b_rdata_dbg", rdata, 32'h22222222);
    advance();
    dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0044;
    compare(); advance();
    idle(); rst = 1;
    compare(); check("rstmid_dbg_rvalid", {31'b0, dbg_rvalid}, 32'd0); advance();
    rst = 0; core_req = 1; dbg_req = 1; core_addr = 16'h0050;
    compare();
    check("rstmid_dbg_rvalid2", {31'b0, dbg_rvalid}, 32'd0);
    check("rstmid_core_wins", {31'b0, core_gnt}, 32'd1);
    advance();
    for (int n = 0; n < 3000; n++) begin
      hold_c = core_req && !e_cw && !rst;
      hold_d = dbg_req && !e_dw && !rst;
      rst = ($urandom_range(0, 199) == 0);
      if (!hold_c) begin
        core_req = ($urandom_range(0, 3) != 0); core_we = $urandom_range(0, 1);
        core_addr = AW'($urandom); core_wdata = $urandom;
      end
      if (!hold_d) begin
        dbg_req = ($urandom_range(0, 2) == 0); dbg_we = $urandom_range(0, 1);
        dbg_addr = AW'($urandom); dbg_wdata = $urandom;
      end
      if ($urandom_range(0, 7) == 0) dbg_lock = !dbg_lock;
      mem_rdata = $urandom;
      compare(); advance();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
